latch_wr_sequencer: RTL and testbench
=====================================

# latch_wr_sequencer

Write-side sequencer for the block's level-sensitive latch banks. It accepts one address/data write per valid/ready handshake and drives a shared data bus plus one-hot latch enables. Data is held stable for a programmable setup, enable-pulse and hold window, so each transparent-high latch captures cleanly. It sits between a flop-based producer and a bank of `2**ADDR_W` enable-gated latches that share one data bus.

## Interface
- `DATA_W`, 8, width of write data and latch data bus
- `ADDR_W`, 2, latch select width; the bank has `2**ADDR_W` latches
- `SETUP_CYC`, 1, cycles `lat_d` is stable before enable rises; legal range 1..15
- `PULSE_CYC`, 2, cycles enable is held high; legal range 1..15
- `HOLD_CYC`, 1, cycles `lat_d` is stable after enable falls; legal range 1..15

Ports:
- `clk`  in  1  clock; all logic on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  producer has a write pending
- `in_ready`  out  1  sequencer can accept a write
- `in_addr`  in  `ADDR_W`  target latch index
- `in_data`  in  `DATA_W`  value to write
- `lat_d`  out  `DATA_W`  shared latch data bus
- `lat_en`  out  `2**ADDR_W`  one-hot latch enables; bit i drives latch i
- `busy`  out  1  high whenever state is not IDLE
- `done`  out  1  one-cycle pulse when a write completes

## Operation
- FSM states: IDLE, SETUP, PULSE, HOLD. A 4-bit down-counter times each phase.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`, register `in_addr` and `in_data`, load the counter with `SETUP_CYC-1`, and go to SETUP.
- SETUP:
  - `lat_d` = captured data; `lat_en`=0.
  - When the counter reaches 0, load `PULSE_CYC-1` and go to PULSE.
- PULSE:
  - `lat_en` has exactly the bit for the captured address set; `lat_d` is unchanged.
  - When the counter reaches 0, load `HOLD_CYC-1` and go to HOLD.
- HOLD:
  - `lat_en`=0; `lat_d` is unchanged.
  - When the counter reaches 0, go to IDLE and assert `done` for one cycle.
- Output register rules:
  - `lat_en`, `lat_d`, `in_ready`, `busy` and `done` are all direct flop outputs. No combinational decode drives `lat_en`, so the latch gates are glitch-free.
  - `lat_d` keeps its last written value in IDLE. It changes only on the accept edge.
- Inputs are ignored outside IDLE. The producer must hold `in_addr`/`in_data` only until the accept edge.
- At most one `lat_en` bit is ever high. `lat_en` is never high in the same cycle that `lat_d` changes.
- Reset, asynchronous, in any state:
  - state=IDLE, `lat_en`=0, `lat_d`=0, `busy`=0, `done`=0, `in_ready`=0 while `reset` is high.
  - `in_ready` goes to 1 on the first rising edge after `reset` deasserts.
  - A write interrupted by reset is dropped, with no `done`.

## Timing
- Accept edge E0. SETUP occupies cycles E0+1 .. E0+`SETUP_CYC`.
- `lat_en` is high for exactly `PULSE_CYC` consecutive cycles, then HOLD lasts `HOLD_CYC` cycles.
- `done`=1 and `in_ready`=1 in the first IDLE cycle, at E0+`SETUP_CYC`+`PULSE_CYC`+`HOLD_CYC`+1.
- `busy` is high from E0+1 through the last HOLD cycle.
- Throughput is one write per `SETUP_CYC`+`PULSE_CYC`+`HOLD_CYC`+1 cycles; with defaults that is 5.
- A back-to-back `in_valid` is accepted in the `done` cycle. `done` and the next SETUP entry never overlap `lat_en`.

## Configuration
- Macro: `LATCH_WR_SEQUENCER_PARITY_EN`.
- Defined:
  - Adds output port `lat_p` (1 bit), the even parity of the captured data (XOR of all bits).
  - `lat_p` is registered and updates on the accept edge together with `lat_d`. It resets to 0 and follows the same stability window.
- Undefined: the `lat_p` port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset then idle:
  - Stimulus: assert `reset` mid-cycle, release it.
  - Required: `lat_en`=0, `lat_d`=0x00, `busy`=0 immediately after assertion; `in_ready`=1 one edge after release.
- Single write, defaults:
  - Stimulus: `in_addr`=2, `in_data`=0xA5, accepted at E0.
  - Required: `lat_d`=0xA5 from E0+1; `lat_en`=4'b0100 at E0+2 and E0+3 only; `done` at E0+5.
- Back-to-back:
  - Stimulus: `in_valid` held high; writes (0,0x11) then (3,0xEE).
  - Required: second accept in the first write's `done` cycle; `lat_en`=4'b0001 then 4'b1000; `lat_d` never changes while any `lat_en` bit is high.
- Reset mid-PULSE:
  - Stimulus: assert `reset` while `lat_en`=4'b0010.
  - Required: `lat_en`→0 asynchronously; no `done`; next write (1,0x5A) completes normally.
- Parameter sweep:
  - Stimulus: `SETUP_CYC`=3, `PULSE_CYC`=1, `HOLD_CYC`=4; write (0,0x3C).
  - Required: `lat_en` high only at E0+4; `done` at E0+9; `busy` high for 8 cycles.
- Parity (macro defined):
  - Stimulus: write 0x07, then write 0x03.
  - Required: `lat_p`=1 for the first write, 0 for the second; `lat_p` changes only on accept edges.

Source files
------------

// File: rtl/latch_wr_sequencer_if.sv
// Producer handshake plus latch-bank drive bus for latch_wr_sequencer.
// lat_p exists only when LATCH_WR_SEQUENCER_PARITY_EN is defined.
interface latch_wr_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  localparam int NLAT = 2 ** ADDR_W;

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] lat_d;
  logic [NLAT-1:0]   lat_en;
  logic              busy;
  logic              done;
`ifdef LATCH_WR_SEQUENCER_PARITY_EN
  logic              lat_p;
`endif

  modport master (
    output in_valid, in_addr, in_data,
    input  in_ready, lat_d, lat_en, busy, done
`ifdef LATCH_WR_SEQUENCER_PARITY_EN
    , input lat_p
`endif
  );

  modport slave (
    input  in_valid, in_addr, in_data,
    output in_ready, lat_d, lat_en, busy, done
`ifdef LATCH_WR_SEQUENCER_PARITY_EN
    , output lat_p
`endif
  );
endinterface

// File: rtl/latch_wr_sequencer.sv
// Setup/pulse/hold write sequencer for a bank of enable-gated latches.
// Optional parity output under LATCH_WR_SEQUENCER_PARITY_EN.
module latch_wr_sequencer #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 2,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  latch_wr_sequencer_if.slave  bus
);
  localparam int NLAT = 2 ** ADDR_W;
  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
  localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] lat_d_q, lat_d_d;
  logic [NLAT-1:0]   lat_en_q, lat_en_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept;

  assign accept = (state_q == IDLE) && ready_q && bus.in_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = SETUP;
        cnt_d   = SETUP_LD;
      end
      SETUP: if (cnt_q == 4'd0) begin
        state_d = PULSE;
        cnt_d   = PULSE_LD;
      end else cnt_d = cnt_q - 4'd1;
      PULSE: if (cnt_q == 4'd0) begin
        state_d = HOLD;
        cnt_d   = HOLD_LD;
      end else cnt_d = cnt_q - 4'd1;
      HOLD: if (cnt_q == 4'd0) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else cnt_d = cnt_q - 4'd1;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so every pin is a plain flop.
  always_comb begin
    addr_d   = accept ? bus.in_addr : addr_q;
    lat_d_d  = accept ? bus.in_data : lat_d_q;
    lat_en_d = (state_d == PULSE) ? (NLAT'(1) << addr_q) : '0;
    busy_d   = (state_d != IDLE);
    ready_d  = (state_d == IDLE);
    done_d   = (state_q == HOLD) && (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q   <= '0;
      lat_d_q  <= '0;
      lat_en_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      lat_d_q  <= lat_d_d;
      lat_en_q <= lat_en_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.in_ready = ready_q;
  assign bus.lat_d    = lat_d_q;
  assign bus.lat_en   = lat_en_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

`ifdef LATCH_WR_SEQUENCER_PARITY_EN
  logic lat_p_q, lat_p_d;

  assign lat_p_d = accept ? ^bus.in_data : lat_p_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lat_p_q <= 1'b0;
    else       lat_p_q <= lat_p_d;
  end

  assign bus.lat_p = lat_p_q;
`endif
endmodule

// File: tb/tb_latch_wr_sequencer.sv
// Bench for latch_wr_sequencer: default instance (A) and a 3/1/4 timing instance (B),
// checked every cycle against a write-timeline model plus directed literals.
module tb_latch_wr_sequencer;
  logic clk   = 1'b0;
  logic reset = 1'b0;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  latch_wr_sequencer_if #(.DATA_W(8), .ADDR_W(2)) ifa ();
  latch_wr_sequencer_if #(.DATA_W(8), .ADDR_W(2)) ifb ();

  latch_wr_sequencer #(.DATA_W(8), .ADDR_W(2), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1))
    u_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  latch_wr_sequencer #(.DATA_W(8), .ADDR_W(2), .SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(4))
    u_b (.clk(clk), .reset(reset), .bus(ifb.slave));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each write is a timeline indexed by k = cycles since its accept edge.
  function automatic int s_of(int i); return (i == 0) ? 1 : 3; endfunction
  function automatic int p_of(int i); return (i == 0) ? 2 : 1; endfunction
  function automatic int t_of(int i); return (i == 0) ? 4 : 8; endfunction

  bit         m_act[2];
  bit         m_seen[2];
  int         m_k[2];
  logic [1:0] m_addr[2];
  logic [7:0] m_data[2];

  function automatic bit m_ready(int i);
    return m_seen[i] && (!m_act[i] || m_k[i] > t_of(i));
  endfunction
  function automatic logic [3:0] m_en(int i);
    if (m_act[i] && m_k[i] > s_of(i) && m_k[i] <= s_of(i) + p_of(i))
      return 4'b0001 << m_addr[i];
    return 4'b0000;
  endfunction
  function automatic bit m_busy(int i);
    return m_act[i] && m_k[i] >= 1 && m_k[i] <= t_of(i);
  endfunction
  function automatic bit m_done(int i);
    return m_act[i] && m_k[i] == t_of(i) + 1;
  endfunction

  always @(posedge clk or posedge reset) begin
    bit         vld[2];
    logic [1:0] ad[2];
    logic [7:0] da[2];
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] = 0; m_seen[i] = 0; m_k[i] = 0; m_addr[i] = '0; m_data[i] = '0;
      end
    end else begin
      vld[0] = ifa.in_valid; ad[0] = ifa.in_addr; da[0] = ifa.in_data;
      vld[1] = ifb.in_valid; ad[1] = ifb.in_addr; da[1] = ifb.in_data;
      for (int i = 0; i < 2; i++) begin
        if (m_ready(i) && vld[i]) begin
          m_act[i] = 1; m_k[i] = 1; m_addr[i] = ad[i]; m_data[i] = da[i];
        end else if (m_act[i] && m_k[i] <= t_of(i)) m_k[i]++;
        else if (m_act[i]) m_k[i] = t_of(i) + 2;
        m_seen[i] = 1;
      end
    end
  end

  logic [7:0] prev_d[2];

  always @(negedge clk) begin
    logic [7:0] d[2];
    logic [3:0] en[2];
    logic       rd[2], bz[2], dn[2];
`ifdef LATCH_WR_SEQUENCER_PARITY_EN
    logic       pp[2];
    pp[0] = ifa.lat_p; pp[1] = ifb.lat_p;
`endif
    d[0] = ifa.lat_d; en[0] = ifa.lat_en; rd[0] = ifa.in_ready; bz[0] = ifa.busy; dn[0] = ifa.done;
    d[1] = ifb.lat_d; en[1] = ifb.lat_en; rd[1] = ifb.in_ready; bz[1] = ifb.busy; dn[1] = ifb.done;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("dut%0d.lat_d", i), 32'(d[i]), 32'(m_data[i]));
      chk($sformatf("dut%0d.lat_en", i), 32'(en[i]), 32'(m_en(i)));
      chk($sformatf("dut%0d.in_ready", i), 32'(rd[i]), 32'(m_ready(i)));
      chk($sformatf("dut%0d.busy", i), 32'(bz[i]), 32'(m_busy(i)));
      chk($sformatf("dut%0d.done", i), 32'(dn[i]), 32'(m_done(i)));
      chk($sformatf("dut%0d.en_onehot", i), 32'($countones(en[i]) <= 1), 32'd1);
      if (en[i] != 4'b0000)
        chk($sformatf("dut%0d.lat_d_stable_under_en", i), 32'(d[i]), 32'(prev_d[i]));
`ifdef LATCH_WR_SEQUENCER_PARITY_EN
      chk($sformatf("dut%0d.lat_p", i), 32'(pp[i]), 32'(^m_data[i]));
`endif
      prev_d[i] = d[i];
    end
  end

  function automatic logic dut_ready(int i);
    return (i == 0) ? ifa.in_ready : ifb.in_ready;
  endfunction

  // Waits for ready, offers one write, returns at negedge+1 of cycle k=1.
  task automatic write(input int i, input logic [1:0] a, input logic [7:0] dat, input bit keep = 0);
    int n = 0;
    while (!dut_ready(i) && n < 50) begin
      @(negedge clk); #1; n++;
    end
    chk("ready_timeout", 32'(dut_ready(i)), 32'd1);
    if (i == 0) begin ifa.in_valid = 1; ifa.in_addr = a; ifa.in_data = dat; end
    else        begin ifb.in_valid = 1; ifb.in_addr = a; ifb.in_data = dat; end
    @(posedge clk);
    @(negedge clk); #1;
    if (!keep) begin
      if (i == 0) ifa.in_valid = 0; else ifb.in_valid = 0;
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  initial begin
    int nd;
    ifa.in_valid = 0; ifa.in_addr = '0; ifa.in_data = '0;
    ifb.in_valid = 0; ifb.in_addr = '0; ifb.in_data = '0;
    prev_d[0] = '0; prev_d[1] = '0;

    // Reset then idle
    #1 reset = 1;
    step(1);
    chk("rst.lat_en", 32'(ifa.lat_en), 32'h0);
    chk("rst.lat_d", 32'(ifa.lat_d), 32'h00);
    chk("rst.busy", 32'(ifa.busy), 32'h0);
    chk("rst.in_ready", 32'(ifa.in_ready), 32'h0);
    reset = 0;
    step(1);
    chk("rst.ready_after_release", 32'(ifa.in_ready), 32'h1);

    // Single write, defaults
    write(0, 2'd2, 8'hA5);
    chk("w1.k1.lat_d", 32'(ifa.lat_d), 32'hA5);
    chk("w1.k1.lat_en", 32'(ifa.lat_en), 32'h0);
    step(1); chk("w1.k2.lat_en", 32'(ifa.lat_en), 32'b0100);
    step(1); chk("w1.k3.lat_en", 32'(ifa.lat_en), 32'b0100);
    step(1); chk("w1.k4.lat_en", 32'(ifa.lat_en), 32'h0);
             chk("w1.k4.busy", 32'(ifa.busy), 32'h1);
    step(1); chk("w1.k5.done", 32'(ifa.done), 32'h1);
             chk("w1.k5.in_ready", 32'(ifa.in_ready), 32'h1);

    // Back-to-back with in_valid held high
    write(0, 2'd0, 8'h11, 1);
    ifa.in_addr = 2'd3; ifa.in_data = 8'hEE;
    chk("b2b.k1.lat_d", 32'(ifa.lat_d), 32'h11);
    step(1); chk("b2b.k2.lat_en", 32'(ifa.lat_en), 32'b0001);
    step(3); chk("b2b.k5.done", 32'(ifa.done), 32'h1);
             chk("b2b.k5.in_ready", 32'(ifa.in_ready), 32'h1);
    step(1); chk("b2b.w2.k1.lat_d", 32'(ifa.lat_d), 32'hEE);
             chk("b2b.w2.k1.busy", 32'(ifa.busy), 32'h1);
    ifa.in_valid = 0;
    step(2); chk("b2b.w2.k3.lat_en", 32'(ifa.lat_en), 32'b1000);
    step(2); chk("b2b.w2.k5.done", 32'(ifa.done), 32'h1);

    // Reset mid-PULSE
    write(0, 2'd1, 8'h96);
    step(1); chk("rp.k2.lat_en", 32'(ifa.lat_en), 32'b0010);
    #2 reset = 1;
    #1;
    chk("rp.async.lat_en", 32'(ifa.lat_en), 32'h0);
    chk("rp.async.busy", 32'(ifa.busy), 32'h0);
    chk("rp.async.lat_d", 32'(ifa.lat_d), 32'h0);
    step(1);
    reset = 0;
    nd = 0;
    repeat (8) begin step(1); nd += int'(ifa.done); end
    chk("rp.no_done", 32'(nd), 32'd0);
    write(0, 2'd1, 8'h5A);
    chk("rp.w.k1.lat_d", 32'(ifa.lat_d), 32'h5A);
    step(1); chk("rp.w.k2.lat_en", 32'(ifa.lat_en), 32'b0010);
    step(3); chk("rp.w.k5.done", 32'(ifa.done), 32'h1);

    // Parameter sweep on instance B (3/1/4)
    write(1, 2'd0, 8'h3C);
    nd = 0;
    for (int k = 1; k <= 9; k++) begin
      chk($sformatf("sw.k%0d.lat_en", k), 32'(ifb.lat_en), (k == 4) ? 32'b0001 : 32'h0);
      chk($sformatf("sw.k%0d.done", k), 32'(ifb.done), (k == 9) ? 32'h1 : 32'h0);
      nd += int'(ifb.busy);
      if (k < 9) step(1);
    end
    chk("sw.busy_cycles", 32'(nd), 32'd8);

`ifdef LATCH_WR_SEQUENCER_PARITY_EN
    write(0, 2'd0, 8'h07);
    chk("par.w1.lat_p", 32'(ifa.lat_p), 32'h1);
    step(4);
    chk("par.w1.k5.lat_p", 32'(ifa.lat_p), 32'h1);
    write(0, 2'd0, 8'h03);
    chk("par.w2.lat_p", 32'(ifa.lat_p), 32'h0);
`endif

    step(6);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
